fetch_block: RTL and testbench

FETCH_BLOCK -- requirements
Module: fetch_block

---
 rtl/fetch_block.sv | 109 ++++++++++
 tb/tb_fetch_block.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_block.sv
// Thumb instruction fetch: single-outstanding memory requests feeding a small
// prefetch FIFO that presents instructions and their addresses to decode.
module fetch_block #(
    parameter int               WORD        = 32,
    parameter int               INSTR_WIDTH = 16,
    parameter int               FIFO_DEPTH  = 2,
    parameter logic [WORD-1:0]  RESET_PC    = '0
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    output logic                   imem_req_o,
    output logic [WORD-1:0]        imem_addr_o,
    input  logic                   imem_valid_i,
    input  logic [INSTR_WIDTH-1:0] imem_data_i,
    input  logic                   redirect_i,
    input  logic [WORD-1:0]        redirect_addr_i,
    input  logic                   stall_i,
    output logic [INSTR_WIDTH-1:0] instruction_o,
    output logic [WORD-1:0]        instr_addr_o,
    output logic                   instr_valid_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        DISCARD
    } state_t;

    state_t                 r_state;
    logic [WORD-1:0]        r_pc;
    logic [INSTR_WIDTH-1:0] r_data [FIFO_DEPTH];
    logic [WORD-1:0]        r_addr [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wptr;
    logic [PTR_W-1:0]       r_rptr;
    logic [CNT_W-1:0]       r_count;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_unused;

    // Halfword alignment: the low redirect bit carries no information.
    assign w_unused = redirect_addr_i[0];

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_push  = (r_state == WAIT) && imem_valid_i && !redirect_i;
    assign w_pop   = !w_empty && !stall_i && !redirect_i;

    assign imem_req_o    = (r_state == FETCH) && !w_full && !redirect_i;
    assign imem_addr_o   = r_pc;
    assign instr_valid_o = !w_empty;
    assign instruction_o = w_empty ? '0 : r_data[r_rptr];
    assign instr_addr_o  = w_empty ? '0 : r_addr[r_rptr];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= FETCH;
            r_pc    <= RESET_PC;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            unique case (r_state)
                FETCH: begin
                    if (imem_req_o)
                        r_state <= WAIT;
                end
                WAIT: begin
                    if (redirect_i)
                        r_state <= imem_valid_i ? FETCH : DISCARD;
                    else if (imem_valid_i)
                        r_state <= FETCH;
                end
                DISCARD: begin
                    if (imem_valid_i)
                        r_state <= FETCH;
                end
                default: r_state <= FETCH;
            endcase

            // Redirect flushes everything and wins over push/pop.
            if (redirect_i) begin
                r_pc    <= {redirect_addr_i[WORD-1:1], 1'b0};
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_data[r_wptr] <= imem_data_i;
                    r_addr[r_wptr] <= r_pc;
                    r_wptr         <= r_wptr + PTR_W'(1);
                    r_pc           <= r_pc + WORD'(2);
                end
                if (w_pop)
                    r_rptr <= r_rptr + PTR_W'(1);
                if (w_push && !w_pop)
                    r_count <= r_count + CNT_W'(1);
                else if (!w_push && w_pop)
                    r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_block.sv
// Randomized scoreboard bench for fetch_block: a memory model answers requests,
// the expected address stream is rebuilt on every reset/redirect.
module tb_fetch_block;

    localparam int          WORD  = 32;
    localparam int          IW    = 16;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'hFFFF_FFFC;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          imem_req_o;
    logic [31:0]   imem_addr_o;
    logic          imem_valid_i = 1'b0;
    logic [15:0]   imem_data_i = '0;
    logic          redirect_i = 1'b0;
    logic [31:0]   redirect_addr_i = '0;
    logic          stall_i = 1'b0;
    logic [15:0]   instruction_o;
    logic [31:0]   instr_addr_o;
    logic          instr_valid_o;

    always #5 clk = ~clk;

    fetch_block #(
        .WORD(WORD), .INSTR_WIDTH(IW), .FIFO_DEPTH(DEPTH), .RESET_PC(RPC)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_valid_i(imem_valid_i), .imem_data_i(imem_data_i),
        .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
        .stall_i(stall_i),
        .instruction_o(instruction_o), .instr_addr_o(instr_addr_o),
        .instr_valid_o(instr_valid_o)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];
    bit go = 0;
    bit mem_busy = 0;
    int mem_cnt = 0;
    logic [31:0] mem_addr = '0;
    int min_delay = 0;
    int max_delay = 0;
    bit last_req = 0;

    // Memory contents: a fixed function of the halfword address.
    function automatic logic [15:0] mem_f(input logic [31:0] a);
        return a[16:1] ^ a[31:16] ^ 16'hA5C3;
    endfunction

    // Sequential fetch from t onward, wrapping mod 2^32.
    function automatic void load_stream(input logic [31:0] t);
        exp_q.delete();
        for (int i = 0; i < 400; i++)
            exp_q.push_back(t + 32'(2 * i));
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit rst, input bit rd,
                         input logic [31:0] tgt, input bit st);
        @(negedge clk);
        if (mem_busy && mem_cnt == 0) begin
            imem_valid_i = 1'b1;
            imem_data_i  = mem_f(mem_addr);
            mem_busy     = 0;
        end else begin
            imem_valid_i = 1'b0;
            imem_data_i  = 16'($urandom);
            if (mem_busy) mem_cnt--;
        end
        reset_i         = rst;
        redirect_i      = rd;
        redirect_addr_i = tgt;
        stall_i         = st;
        if (rst) begin
            load_stream(RPC);
            // a stale response may still land right after reset
            if (mem_busy) mem_cnt = 0;
        end else if (rd) begin
            load_stream({tgt[31:1], 1'b0});
        end
        #1;
        last_req = imem_req_o && !rst;
        if (last_req) begin
            check("single_outstanding", {31'b0, mem_busy}, 32'd0);
            mem_busy = 1;
            mem_addr = imem_addr_o;
            mem_cnt  = $urandom_range(max_delay, min_delay);
        end
    endtask

    // Monitor: pops the scoreboard whenever decode consumes an instruction.
    initial begin
        bit prev_rst;
        bit prev_rd;
        logic [31:0] prev_tgt;
        logic [31:0] e;
        prev_rst = 0;
        prev_rd  = 0;
        prev_tgt = '0;
        wait (go);
        forever begin
            @(negedge clk);
            #2;
            if (prev_rst) begin
                check("after_reset_valid", {31'b0, instr_valid_o}, 32'd0);
                check("after_reset_pc", imem_addr_o, RPC);
            end else if (prev_rd) begin
                check("after_redirect_valid", {31'b0, instr_valid_o}, 32'd0);
                check("after_redirect_pc", imem_addr_o, prev_tgt);
            end
            if (!reset_i && !redirect_i && instr_valid_o && !stall_i) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL pop_underflow: got %h expected none", instr_addr_o);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_addr", instr_addr_o, e);
                    check("pop_data", {16'h0, instruction_o}, {16'h0, mem_f(e)});
                end
            end else if (!instr_valid_o) begin
                check("empty_instr", {16'h0, instruction_o}, 32'd0);
                check("empty_addr", instr_addr_o, 32'd0);
            end
            prev_rst = reset_i;
            prev_rd  = redirect_i && !reset_i;
            prev_tgt = {redirect_addr_i[31:1], 1'b0};
        end
    end

    initial begin
        bit seen;
        logic [31:0] tgt;
        go = 1;
        cycle(1, 0, '0, 0);
        cycle(1, 0, '0, 0);

        // reset outputs, then stall with zero-wait memory until full
        cycle(0, 0, '0, 1);
        check("reset_req", {31'b0, last_req}, 32'd1);
        check("reset_imem_addr", mem_addr, RPC);
        for (int i = 0; i < 5; i++) cycle(0, 0, '0, 1);
        check("full_valid", {31'b0, instr_valid_o}, 32'd1);
        check("full_head", instr_addr_o, RPC);
        check("full_no_req", {31'b0, imem_req_o}, 32'd0);
        check("full_next_pc", imem_addr_o, RPC + 32'd4);
        for (int i = 0; i < 12; i++) cycle(0, 0, '0, 0);

        // redirect while a request waits, response two cycles later
        min_delay = 2;
        max_delay = 2;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle(0, 0, '0, 0);
            seen = last_req;
        end
        check("redir_req_seen", {31'b0, seen}, 32'd1);
        cycle(0, 1, 32'h101, 0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle(0, 0, '0, 0);
            seen = instr_valid_o;
        end
        check("redir_first_valid", {31'b0, seen}, 32'd1);
        check("redir_first_addr", instr_addr_o, 32'h100);

        // randomized traffic
        min_delay = 0;
        max_delay = 3;
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(999, 0);
            if (r < 4) begin
                cycle(1, 0, '0, 0);
            end else if (r < 50) begin
                tgt = (r < 10) ? 32'hFFFF_FFFF : $urandom;
                cycle(0, 1, tgt, $urandom_range(1, 0) == 1);
            end else begin
                cycle(0, 0, 32'($urandom), $urandom_range(9, 0) < 3);
            end
        end

        for (int i = 0; i < 30; i++) cycle(0, 0, '0, 0);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
